// File: rtl/debug_ocimem_arbiter_if.sv
// Shared OCI RAM bus: the CPU-side request/response handshake and the single
// RAM port. The arbiter takes the slave view. The CPU and RAM environment
// take the master view.
interface debug_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // CPU-side handshake
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_grant;
  logic              cpu_rdata_valid;
  logic [DATA_W-1:0] cpu_rdata;

  // OCI RAM port
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_grant, cpu_rdata_valid, cpu_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_grant, cpu_rdata_valid, cpu_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/debug_ocimem_arbiter.sv
// Arbitrates the single OCI RAM port between the JTAG debug monitor and the
// CPU. JTAG strobes post at most one operation into a holding register. A
// round-robin IDLE/ISSUE/CAPTURE FSM serves either that operation or the CPU
// request, one RAM access at a time.
module debug_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  input  logic [37:0]           jdo,
  debug_ocimem_arbiter_if.slave bus,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // JTAG holding register plus the flag for an operation that left it
  logic              jtag_pend;
  logic              jtag_pend_we;
  logic [DATA_W-1:0] jtag_pend_data;
  logic              jtag_fly;
  logic [ADDR_W-1:0] jtag_addr;

  // Arbitration and the latched operation currently owning the RAM port
  logic              prefer_jtag;
  logic              sel_jtag;
  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;

  logic              cpu_rdata_valid_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  logic start_op;
  logic win_jtag;

  // The strobe decode runs straight from jdo. These bits carry no meaning here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  logic jtag_busy;
  logic any_strobe;
  logic accept;
  logic overrun;
  logic err_clear;

  assign jtag_busy     = jtag_pend | jtag_fly;
  assign any_strobe    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign accept        = any_strobe & ~jtag_busy;
  assign overrun       = any_strobe & jtag_busy;
  assign err_clear     = take_action_ocimem_a & jdo[34];
  assign monitor_ready = ~jtag_busy;

  assign bus.cpu_rdata_valid = cpu_rdata_valid_q;
  assign bus.cpu_rdata       = cpu_rdata_q;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments, so every
    // flop samples values from before the edge and block order cannot matter.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, winner selection and the RAM and grant strobes
  always_comb begin
    // NOTE: every output gets a default before the case statement. Without
    // it, the paths through the case that do not assign an output would
    // infer a latch.
    state_d       = state_q;
    start_op      = 1'b0;
    win_jtag      = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = op_addr;
    bus.ram_wdata = op_wdata;
    bus.cpu_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (jtag_pend || bus.cpu_req) begin
          start_op = 1'b1;
          win_jtag = jtag_pend && (prefer_jtag || !bus.cpu_req);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = op_we;
        bus.cpu_grant = !sel_jtag;
        state_d       = op_we ? IDLE : CAPTURE;
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A reset cycle aborts the access before the RAM or the CPU can act on it.
    if (reset) begin
      bus.ram_en    = 1'b0;
      bus.ram_we    = 1'b0;
      bus.cpu_grant = 1'b0;
    end
  end

  // JTAG front end: strobe acceptance, overrun flag and the address counter
  always_ff @(posedge clk) begin
    if (reset) begin
      jtag_pend      <= 1'b0;
      jtag_pend_we   <= 1'b0;
      jtag_pend_data <= '0;
      jtag_fly       <= 1'b0;
      jtag_addr      <= '0;
      monitor_error  <= 1'b0;
    end else begin
      // A new overrun beats a clear that arrives in the same cycle.
      if (overrun)        monitor_error <= 1'b1;
      else if (err_clear) monitor_error <= 1'b0;

      if (accept) begin
        if (take_action_ocimem_a) begin
          jtag_addr <= jdo[ADDR_W+16:17];
          if (jdo[35]) begin
            jtag_pend    <= 1'b1;
            jtag_pend_we <= 1'b0;
          end
        end else if (take_action_ocimem_b) begin
          jtag_pend      <= 1'b1;
          jtag_pend_we   <= 1'b1;
          jtag_pend_data <= DATA_W'(jdo[34:3]);
        end else begin
          jtag_pend    <= 1'b1;
          jtag_pend_we <= 1'b0;
        end
      end

      // Accept needs an empty holder, so it never coincides with this hand-off.
      if (start_op && win_jtag) begin
        jtag_pend <= 1'b0;
        jtag_fly  <= 1'b1;
      end

      if (state_q == ISSUE && sel_jtag) begin
        jtag_addr <= jtag_addr + 1'b1;
        if (op_we) jtag_fly <= 1'b0;
      end

      if (state_q == CAPTURE && sel_jtag) jtag_fly <= 1'b0;
    end
  end

  // Latch the winning operation and advance the round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      prefer_jtag <= 1'b1;
      sel_jtag    <= 1'b0;
      op_we       <= 1'b0;
      op_addr     <= '0;
      op_wdata    <= '0;
    end else if (start_op) begin
      sel_jtag    <= win_jtag;
      prefer_jtag <= !win_jtag;
      if (win_jtag) begin
        op_we    <= jtag_pend_we;
        op_addr  <= jtag_addr;
        op_wdata <= jtag_pend_data;
      end else begin
        op_we    <= bus.cpu_we;
        op_addr  <= bus.cpu_addr;
        op_wdata <= bus.cpu_wdata;
      end
    end
  end

  // Capture read data for whichever side owned the read
  always_ff @(posedge clk) begin
    if (reset) begin
      MonDReg           <= '0;
      cpu_rdata_q       <= '0;
      cpu_rdata_valid_q <= 1'b0;
    end else begin
      cpu_rdata_valid_q <= 1'b0;
      if (state_q == CAPTURE) begin
        if (sel_jtag) begin
          MonDReg <= bus.ram_rdata;
        end else begin
          cpu_rdata_q       <= bus.ram_rdata;
          cpu_rdata_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_ocimem_arbiter.sv
// Directed bench for debug_ocimem_arbiter. A behavioural RAM answers reads
// one cycle after ram_en. Each task drives one scenario and checks its
// hand-computed expectations.
module tb_debug_ocimem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        act_a, act_b, noact_a;
  logic [37:0] jdo;
  logic [31:0] mon;
  logic        ready, err;

  int n_cmp = 0;
  int n_bad = 0;

  debug_ocimem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  debug_ocimem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (act_a),
    .take_action_ocimem_b    (act_b),
    .take_no_action_ocimem_a (noact_a),
    .jdo                     (jdo),
    .bus                     (bus),
    .MonDReg                 (mon),
    .monitor_ready           (ready),
    .monitor_error           (err)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words return a fixed preload pattern.
  logic [31:0] ram [256];
  bit          written [256];

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 32'hDEAD_BEEF;
      8'h20:   return 32'h1234_5678;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] ram_peek(input logic [7:0] a);
    return written[a] ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        ram[bus.ram_addr]     <= bus.ram_wdata;
        written[bus.ram_addr] <= 1'b1;
      end else begin
        bus.ram_rdata <= ram_peek(bus.ram_addr);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobes_off();
    act_a = 1'b0; act_b = 1'b0; noact_a = 1'b0; jdo = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    strobes_off();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    tick(2);
    n_cmp++; if (bus.ram_en !== 1'b0) begin n_bad++; $display("FAIL rst_ram_en: got %b want 0", bus.ram_en); end
    n_cmp++; if (bus.cpu_grant !== 1'b0) begin n_bad++; $display("FAIL rst_grant: got %b want 0", bus.cpu_grant); end
    reset = 1'b0;
    tick();
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", err); end
    n_cmp++; if (mon !== 32'h0) begin n_bad++; $display("FAIL rst_mondreg: got %h want 0", mon); end
    n_cmp++; if (bus.cpu_rdata_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", bus.cpu_rdata_valid); end
    n_cmp++; if (dut.jtag_addr !== 8'h00) begin n_bad++; $display("FAIL rst_jtag_addr: got %h want 00", dut.jtag_addr); end
  endtask

  task automatic test_jtag_read();
    jdo = '0; jdo[35] = 1'b1; jdo[24:17] = 8'h10; act_a = 1'b1;
    tick(); strobes_off();
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL jrd_ready_low: got %b want 0", ready); end
    tick();
    n_cmp++; if ({bus.ram_en, bus.ram_we} !== 2'b10) begin n_bad++; $display("FAIL jrd_issue: got en/we %b%b want 10", bus.ram_en, bus.ram_we); end
    n_cmp++; if (bus.ram_addr !== 8'h10) begin n_bad++; $display("FAIL jrd_addr: got %h want 10", bus.ram_addr); end
    tick();
    n_cmp++; if (mon !== 32'h0) begin n_bad++; $display("FAIL jrd_early: got %h want 0", mon); end
    tick();
    n_cmp++; if (mon !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL jrd_data: got %h want deadbeef", mon); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL jrd_ready_back: got %b want 1", ready); end
    n_cmp++; if (dut.jtag_addr !== 8'h11) begin n_bad++; $display("FAIL jrd_inc: got %h want 11", dut.jtag_addr); end
  endtask

  task automatic test_overrun();
    jdo = '0; jdo[34:3] = 32'hCAFE_F00D; act_b = 1'b1;
    tick();
    jdo[34:3] = 32'h1111_1111;
    tick(); strobes_off();
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", err); end
    n_cmp++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h11 || bus.ram_wdata !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL ovr_write: got we %b addr %h data %h want 1 11 cafef00d", bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    tick(3);
    n_cmp++; if (ram_peek(8'h11) !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL ovr_ram: got %h want cafef00d", ram_peek(8'h11)); end
    n_cmp++; if (ram_peek(8'h12) !== 32'h0) begin n_bad++; $display("FAIL ovr_dropped: got %h want 0", ram_peek(8'h12)); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", err); end
    // Address load of 0xFF with error clear and no read
    jdo = '0; jdo[34] = 1'b1; jdo[24:17] = 8'hFF; act_a = 1'b1;
    tick(); strobes_off();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", err); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL ovr_noread_ready: got %b want 1", ready); end
    n_cmp++; if (dut.jtag_addr !== 8'hFF) begin n_bad++; $display("FAIL ovr_load: got %h want ff", dut.jtag_addr); end
  endtask

  task automatic test_wrap();
    jdo = '0; jdo[34:3] = 32'h0BAD_C0DE; act_b = 1'b1;
    tick(); strobes_off();
    tick();
    n_cmp++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 8'hFF) begin
      n_bad++; $display("FAIL wrap_issue: got en %b we %b addr %h want 1 1 ff", bus.ram_en, bus.ram_we, bus.ram_addr);
    end
    tick();
    n_cmp++; if (ram_peek(8'hFF) !== 32'h0BAD_C0DE) begin n_bad++; $display("FAIL wrap_ram: got %h want 0badc0de", ram_peek(8'hFF)); end
    n_cmp++; if (dut.jtag_addr !== 8'h00) begin n_bad++; $display("FAIL wrap_addr: got %h want 00", dut.jtag_addr); end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready: got %b want 1", ready); end
  endtask

  task automatic test_priority();
    jdo = '0; jdo[35] = 1'b1; jdo[24:17] = 8'h20; act_a = 1'b1; noact_a = 1'b1;
    tick(); strobes_off();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL prio_error: got %b want 0", err); end
    tick(3);
    n_cmp++; if (mon !== 32'h1234_5678) begin n_bad++; $display("FAIL prio_data: got %h want 12345678", mon); end
    n_cmp++; if (dut.jtag_addr !== 8'h21) begin n_bad++; $display("FAIL prio_addr: got %h want 21", dut.jtag_addr); end
    tick();
    n_cmp++; if (ready !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL prio_quiet: got ready %b err %b want 1 0", ready, err); end
  endtask

  task automatic test_cpu_read();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    tick();
    n_cmp++; if (bus.cpu_grant !== 1'b1 || bus.ram_en !== 1'b1 || bus.ram_addr !== 8'h10) begin
      n_bad++; $display("FAIL cpu_issue: got grant %b en %b addr %h want 1 1 10", bus.cpu_grant, bus.ram_en, bus.ram_addr);
    end
    bus.cpu_req = 1'b0;
    tick();
    n_cmp++; if (bus.cpu_rdata_valid !== 1'b0) begin n_bad++; $display("FAIL cpu_early: got %b want 0", bus.cpu_rdata_valid); end
    tick();
    n_cmp++; if (bus.cpu_rdata_valid !== 1'b1 || bus.cpu_rdata !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL cpu_data: got valid %b data %h want 1 deadbeef", bus.cpu_rdata_valid, bus.cpu_rdata);
    end
    tick();
    n_cmp++; if (bus.cpu_rdata_valid !== 1'b0 || bus.cpu_grant !== 1'b0) begin
      n_bad++; $display("FAIL cpu_pulse: got valid %b grant %b want 0 0", bus.cpu_rdata_valid, bus.cpu_grant);
    end
  endtask

  // JTAG kept pending and CPU requesting continuously: grants must alternate.
  task automatic test_back_to_back();
    bit got_jtag [4];
    bit exp_jtag [4];
    int ngr;
    exp_jtag = '{1'b1, 1'b0, 1'b1, 1'b0};
    ngr = 0;
    jdo = '0; jdo[34:3] = 32'hA5A5_0001; act_b = 1'b1;
    tick(); act_b = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h40; bus.cpu_wdata = 32'h0C0C_0C0C;
    for (int i = 0; i < 24 && ngr < 4; i++) begin
      tick();
      act_b = 1'b0;
      if (bus.ram_en) begin
        got_jtag[ngr] = !bus.cpu_grant;
        ngr++;
      end
      if (ngr >= 4) bus.cpu_req = 1'b0;
      if (ready && ngr < 3) act_b = 1'b1;
    end
    strobes_off(); bus.cpu_req = 1'b0;
    n_cmp++; if (ngr !== 4) begin n_bad++; $display("FAIL rr_count: got %0d grants want 4", ngr); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (got_jtag[k] !== exp_jtag[k]) begin n_bad++; $display("FAIL rr_grant%0d: got jtag=%b want jtag=%b", k, got_jtag[k], exp_jtag[k]); end
    end
    tick(2);
  endtask

  // Last grant went to JTAG, so a tie must now go to the CPU.
  task automatic test_rr_cpu_first();
    jdo = '0; jdo[34:3] = 32'h0000_0077; act_b = 1'b1;
    tick(); strobes_off();
    tick(3);
    jdo = '0; jdo[34:3] = 32'h5555_AAAA; act_b = 1'b1;
    tick(); strobes_off();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h20;
    tick();
    n_cmp++; if (bus.cpu_grant !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'h20) begin
      n_bad++; $display("FAIL rrc_cpu_wins: got grant %b we %b addr %h want 1 0 20", bus.cpu_grant, bus.ram_we, bus.ram_addr);
    end
    bus.cpu_req = 1'b0;
    tick(2);
    n_cmp++; if (bus.cpu_rdata_valid !== 1'b1 || bus.cpu_rdata !== 32'h1234_5678) begin
      n_bad++; $display("FAIL rrc_cpu_data: got valid %b data %h want 1 12345678", bus.cpu_rdata_valid, bus.cpu_rdata);
    end
    tick();
    n_cmp++; if (bus.ram_en !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 8'h24 || bus.ram_wdata !== 32'h5555_AAAA) begin
      n_bad++; $display("FAIL rrc_jtag_next: got en %b we %b addr %h data %h want 1 1 24 5555aaaa", bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    tick(2);
  endtask

  task automatic test_reset_mid();
    jdo = '0; jdo[34:3] = 32'h0000_0001; act_b = 1'b1;
    tick(); act_b = 1'b0; noact_a = 1'b1;
    tick(); strobes_off();
    tick(3);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_error: got %b want 1", err); end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10;
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.ram_en !== 1'b0 || bus.cpu_grant !== 1'b0) begin
      n_bad++; $display("FAIL rmid_gate: got en %b grant %b want 0 0", bus.ram_en, bus.cpu_grant);
    end
    bus.cpu_req = 1'b0;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.ram_en !== 1'b0 || bus.cpu_rdata_valid !== 1'b0 || ready !== 1'b1 || err !== 1'b0) begin
      n_bad++; $display("FAIL rmid_ctrl: got en %b valid %b ready %b err %b want 0 0 1 0", bus.ram_en, bus.cpu_rdata_valid, ready, err);
    end
    n_cmp++; if (mon !== 32'h0 || bus.cpu_rdata !== 32'h0 || dut.jtag_addr !== 8'h00) begin
      n_bad++; $display("FAIL rmid_regs: got mon %h rdata %h addr %h want 0 0 00", mon, bus.cpu_rdata, dut.jtag_addr);
    end
    tick();
    n_cmp++; if (bus.cpu_rdata_valid !== 1'b0 || bus.ram_en !== 1'b0) begin
      n_bad++; $display("FAIL rmid_after: got valid %b en %b want 0 0", bus.cpu_rdata_valid, bus.ram_en);
    end
  endtask

  initial begin
    test_reset();
    test_jtag_read();
    test_overrun();
    test_wrap();
    test_priority();
    test_cpu_read();
    test_back_to_back();
    test_rr_cpu_first();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
